// File: rtl/snn_pkg.sv
// Shared widths and arithmetic helpers for the spiking delay layer.
package snn_pkg;

  localparam int DATA_W   = 8;
  localparam int WEIGHT_W = 8;

  // Overflow-free accumulator width: u + M signed weights - decay.
  function automatic int acc_width(input int m);
    return DATA_W + $clog2(m + 1) + 2;
  endfunction

  function automatic logic [DATA_W-1:0] clamp_u8(input logic signed [31:0] v);
    if (v < 0) begin
      return '0;
    end else if (v > 255) begin
      return 8'd255;
    end else begin
      return v[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/snn_delay_layer_if.sv
// Data and configuration bundle for snn_delay_layer; the layer is the slave.
interface snn_delay_layer_if #(
  parameter int M  = 4,
  parameter int N  = 8,
  parameter int DW = 3
);
  logic                enable;
  logic                delay_tick;
  logic [M-1:0]        input_spikes;
  logic [N*M*8-1:0]    weights;
  logic [7:0]          threshold;
  logic [7:0]          decay;
  logic [7:0]          refractory_period;
  logic [N*M*DW-1:0]   delay_values;
  logic [N*M-1:0]      delays;
  logic [N*8-1:0]      membrane_potential_out;
  logic [N-1:0]        output_spikes;
  logic [N*8-1:0]      spike_count;

  modport master (
    output enable, delay_tick, input_spikes, weights, threshold, decay,
           refractory_period, delay_values, delays,
    input  membrane_potential_out, output_spikes, spike_count
  );

  modport slave (
    input  enable, delay_tick, input_spikes, weights, threshold, decay,
           refractory_period, delay_values, delays,
    output membrane_potential_out, output_spikes, spike_count
  );
endinterface

// File: rtl/snn_lif_neuron.sv
// One leaky integrate-and-fire neuron with refractory down-counter.
// Optional saturating spike counter built only when SNN_SPIKE_COUNT_EN is defined.
module snn_lif_neuron
  import snn_pkg::*;
#(
  parameter int M = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [M-1:0]          syn_spikes,
  input  logic [M*WEIGHT_W-1:0] weights,
  input  logic [DATA_W-1:0]     threshold,
  input  logic [DATA_W-1:0]     decay,
  input  logic [DATA_W-1:0]     refractory_period,
  output logic [DATA_W-1:0]     membrane_potential,
  output logic                  spike,
  output logic [DATA_W-1:0]     spike_count
);

  localparam int AW = acc_width(M);

  logic [DATA_W-1:0]     u;
  logic [DATA_W-1:0]     refr_cnt;
  logic [DATA_W-1:0]     u_clamped;
  logic signed [AW-1:0]  acc;
  logic                  fire;
  logic                  refractory;

  assign refractory = (refr_cnt != '0);

  always_comb begin
    acc = {{(AW-DATA_W){1'b0}}, u};
    for (int m = 0; m < M; m++) begin
      if (syn_spikes[m]) begin
        acc = acc + {{(AW-WEIGHT_W){weights[m*WEIGHT_W+WEIGHT_W-1]}},
                     weights[m*WEIGHT_W +: WEIGHT_W]};
      end
    end
    acc       = acc - {{(AW-DATA_W){1'b0}}, decay};
    u_clamped = clamp_u8({{(32-AW){acc[AW-1]}}, acc});
    fire      = (u_clamped >= threshold);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      u        <= '0;
      refr_cnt <= '0;
      spike    <= 1'b0;
    end else if (!enable) begin
      spike <= 1'b0;
    end else if (refractory) begin
      refr_cnt <= refr_cnt - 8'd1;
      u        <= '0;
      spike    <= 1'b0;
    end else if (fire) begin
      u        <= '0;
      refr_cnt <= refractory_period;
      spike    <= 1'b1;
    end else begin
      u     <= u_clamped;
      spike <= 1'b0;
    end
  end

  assign membrane_potential = u;

`ifdef SNN_SPIKE_COUNT_EN
  logic [DATA_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (enable && !refractory && fire && (cnt != 8'hFF)) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign spike_count = cnt;
`else
  assign spike_count = '0;
`endif

endmodule

// File: rtl/snn_delay_layer.sv
// Layer of N LIF neurons fed by M inputs through per-synapse programmable delays.
// Spike counters per neuron exist only when SNN_SPIKE_COUNT_EN is defined.
module snn_delay_layer
  import snn_pkg::*;
#(
  parameter int M  = 4,
  parameter int N  = 8,
  parameter int DW = 3
) (
  input  logic               clk,
  input  logic               reset,
  snn_delay_layer_if.slave   bus
);

  localparam int D = (1 << DW) - 1;

  logic [D-1:0]          hist [M];
  logic [N*M-1:0]        eff_spikes;
  logic [DW-1:0]         dv;
  logic [N*DATA_W-1:0]   mp_vec;
  logic [N-1:0]          spk_vec;
  logic [N*DATA_W-1:0]   cnt_vec;

  // History lines shift only on enabled ticks; newest sample lands in bit 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int m = 0; m < M; m++) begin
        hist[m] <= '0;
      end
    end else if (bus.enable && bus.delay_tick) begin
      for (int m = 0; m < M; m++) begin
        hist[m] <= {hist[m][D-2:0], bus.input_spikes[m]};
      end
    end
  end

  // Taps read the registered history, so a coincident tick is seen pre-shift.
  always_comb begin
    eff_spikes = '0;
    dv         = '0;
    for (int n = 0; n < N; n++) begin
      for (int m = 0; m < M; m++) begin
        dv = bus.delay_values[(n*M+m)*DW +: DW];
        if (!bus.delays[n*M+m] || (dv == '0)) begin
          eff_spikes[n*M+m] = bus.input_spikes[m];
        end else begin
          eff_spikes[n*M+m] = hist[m][dv - 1'b1];
        end
      end
    end
  end

  for (genvar n = 0; n < N; n++) begin : gen_neuron
    snn_lif_neuron #(
      .M (M)
    ) u_neuron (
      .clk                (clk),
      .reset              (reset),
      .enable             (bus.enable),
      .syn_spikes         (eff_spikes[n*M +: M]),
      .weights            (bus.weights[n*M*WEIGHT_W +: M*WEIGHT_W]),
      .threshold          (bus.threshold),
      .decay              (bus.decay),
      .refractory_period  (bus.refractory_period),
      .membrane_potential (mp_vec[n*DATA_W +: DATA_W]),
      .spike              (spk_vec[n]),
      .spike_count        (cnt_vec[n*DATA_W +: DATA_W])
    );
  end

  assign bus.membrane_potential_out = mp_vec;
  assign bus.output_spikes          = spk_vec;
  assign bus.spike_count            = cnt_vec;

endmodule

// File: tb/tb_snn_delay_layer.sv
// Directed and randomized bench for snn_delay_layer against an array-based reference model.
module tb_snn_delay_layer;

  localparam int M  = 4;
  localparam int N  = 8;
  localparam int DW = 3;
  localparam int D  = (1 << DW) - 1;
`ifdef SNN_SPIKE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  snn_delay_layer_if #(.M(M), .N(N), .DW(DW)) bus ();

  snn_delay_layer #(.M(M), .N(N), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: potential, remaining refractory cycles, spikes, counts,
  // and per input the samples taken at the last D ticks (index 0 = newest).
  int mu   [N];
  int mref [N];
  int mcnt [N];
  bit mspk [N];
  bit mhist[M][D];

  function automatic int weight_of(int n, int m);
    logic signed [7:0] w;
    w = bus.weights[(n*M+m)*8 +: 8];
    return int'(w);
  endfunction

  function automatic int mp(int n);
    return int'(bus.membrane_potential_out[n*8 +: 8]);
  endfunction

  function automatic int cnt(int n);
    return int'(bus.spike_count[n*8 +: 8]);
  endfunction

  task automatic model_step();
    int acc, dv, s;
    if (reset) begin
      for (int n = 0; n < N; n++) begin
        mu[n] = 0; mref[n] = 0; mcnt[n] = 0; mspk[n] = 0;
      end
      for (int m = 0; m < M; m++)
        for (int k = 0; k < D; k++) mhist[m][k] = 0;
    end else if (!bus.enable) begin
      for (int n = 0; n < N; n++) mspk[n] = 0;
    end else begin
      for (int n = 0; n < N; n++) begin
        if (mref[n] > 0) begin
          mref[n]--; mu[n] = 0; mspk[n] = 0;
        end else begin
          acc = mu[n] - int'(bus.decay);
          for (int m = 0; m < M; m++) begin
            dv = int'(bus.delay_values[(n*M+m)*DW +: DW]);
            if (!bus.delays[n*M+m] || dv == 0) s = int'(bus.input_spikes[m]);
            else s = int'(mhist[m][dv-1]);
            acc += s * weight_of(n, m);
          end
          if (acc < 0) acc = 0;
          if (acc > 255) acc = 255;
          if (acc >= int'(bus.threshold)) begin
            mspk[n] = 1; mu[n] = 0; mref[n] = int'(bus.refractory_period);
            if (CNT_EN && mcnt[n] < 255) mcnt[n]++;
          end else begin
            mspk[n] = 0; mu[n] = acc;
          end
        end
      end
      if (bus.delay_tick) begin
        for (int m = 0; m < M; m++) begin
          for (int k = D-1; k > 0; k--) mhist[m][k] = mhist[m][k-1];
          mhist[m][0] = bus.input_spikes[m];
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [N*8-1:0] e_mp, e_cnt;
    logic [N-1:0]   e_spk;
    for (int n = 0; n < N; n++) begin
      e_mp[n*8 +: 8]  = 8'(mu[n]);
      e_cnt[n*8 +: 8] = 8'(mcnt[n]);
      e_spk[n]        = mspk[n];
    end
    n_checks++;
    assert (bus.membrane_potential_out === e_mp) else begin
      n_errors++;
      $error("FAIL mp_vec observed=%h expected=%h", bus.membrane_potential_out, e_mp);
    end
    n_checks++;
    assert (bus.output_spikes === e_spk) else begin
      n_errors++;
      $error("FAIL spikes observed=%b expected=%b", bus.output_spikes, e_spk);
    end
    n_checks++;
    assert (bus.spike_count === e_cnt) else begin
      n_errors++;
      $error("FAIL count_vec observed=%h expected=%h", bus.spike_count, e_cnt);
    end
  endtask

  task automatic check_int(string tag, int obs, int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic set_w(int n, int m, int val);
    bus.weights[(n*M+m)*8 +: 8] = 8'(val);
  endtask

  task automatic clear_cfg();
    bus.weights           = '0;
    bus.delays            = '0;
    bus.delay_values      = '0;
    bus.threshold         = 8'd100;
    bus.decay             = 8'd0;
    bus.refractory_period = 8'd0;
    bus.input_spikes      = '0;
    bus.delay_tick        = 1'b0;
    bus.enable            = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_cfg();
    bus.enable = 1'b0;
    cycle();
    cycle();
    check_int("reset_u0", mp(0), 0);
    reset = 1'b0;

    // Basic integrate, fire, refractory.
    clear_cfg();
    set_w(0, 0, 50);
    bus.refractory_period = 8'd2;
    bus.input_spikes = 4'b0001;
    cycle();
    check_int("basic_u_first", mp(0), 50);
    check_int("basic_no_spike", int'(bus.output_spikes[0]), 0);
    cycle();
    check_int("basic_spike", int'(bus.output_spikes[0]), 1);
    check_int("basic_u_reset", mp(0), 0);
    cycle();
    check_int("refr1_spike", int'(bus.output_spikes[0]), 0);
    check_int("refr1_u", mp(0), 0);
    cycle();
    check_int("refr2_u", mp(0), 0);
    bus.input_spikes = 4'b0000;
    bus.enable = 1'b0;
    cycle();
    check_int("disabled_spike", int'(bus.output_spikes), 0);

    // Delayed synapse: contribution appears only after the third tick.
    do_reset();
    clear_cfg();
    set_w(0, 0, 50);
    bus.delays[0] = 1'b1;
    bus.delay_values[0 +: DW] = 3'd3;
    bus.input_spikes = 4'b0001; bus.delay_tick = 1'b1;
    cycle();
    check_int("delay_t1", mp(0), 0);
    bus.input_spikes = 4'b0000; bus.delay_tick = 1'b0;
    cycle();
    check_int("delay_gap1", mp(0), 0);
    bus.delay_tick = 1'b1;
    cycle();
    check_int("delay_t2", mp(0), 0);
    bus.delay_tick = 1'b0;
    cycle();
    bus.delay_tick = 1'b1;
    cycle();
    check_int("delay_t3_pre_shift", mp(0), 0);
    bus.delay_tick = 1'b0;
    cycle();
    check_int("delay_visible", mp(0), 50);

    // Clamp low and clamp high.
    do_reset();
    clear_cfg();
    set_w(0, 0, 20);
    bus.input_spikes = 4'b0001;
    cycle();
    check_int("clamp_setup_u20", mp(0), 20);
    set_w(0, 0, -100);
    bus.decay = 8'd5;
    cycle();
    check_int("clamp_low", mp(0), 0);
    bus.decay = 8'd0;
    for (int m = 0; m < M; m++) set_w(1, m, 127);
    bus.threshold = 8'd255;
    bus.input_spikes = 4'b1111;
    cycle();
    check_int("clamp_high_fire", int'(bus.output_spikes[1]), 1);

    // Reset during refractory with populated history.
    do_reset();
    clear_cfg();
    set_w(0, 0, 50);
    bus.threshold = 8'd40;
    bus.refractory_period = 8'd5;
    bus.delays[0] = 1'b1;
    bus.delay_values[0 +: DW] = 3'd1;
    bus.input_spikes = 4'b0001; bus.delay_tick = 1'b1;
    cycle();
    cycle();
    check_int("rst_mid_fire", int'(bus.output_spikes[0]), 1);
    cycle();
    reset = 1'b1;
    cycle();
    check_int("rst_mid_spikes", int'(bus.output_spikes), 0);
    check_int("rst_mid_u0", mp(0), 0);
    reset = 1'b0;
    bus.input_spikes = 4'b0000; bus.delay_tick = 1'b0;
    cycle();
    check_int("rst_hist_empty", mp(0), 0);

    // Randomized operation.
    do_reset();
    clear_cfg();
    for (int c = 0; c < 400; c++) begin
      if (c % 25 == 0) begin
        for (int i = 0; i < (N*M*8)/32; i++) bus.weights[i*32 +: 32] = $urandom;
        bus.delays            = (N*M)'($urandom);
        for (int i = 0; i < N*M; i++) bus.delay_values[i*DW +: DW] = DW'($urandom);
        bus.threshold         = 8'($urandom_range(0, 200));
        bus.decay             = 8'($urandom_range(0, 20));
        bus.refractory_period = 8'($urandom_range(0, 3));
      end
      bus.input_spikes = M'($urandom);
      bus.enable       = ($urandom_range(0, 99) < 85);
      bus.delay_tick   = ($urandom_range(0, 99) < 40);
      reset            = ($urandom_range(0, 99) < 2);
      cycle();
    end
    reset = 1'b0;

    // Counter saturation with continuous firing.
    do_reset();
    clear_cfg();
    bus.threshold = 8'd0;
    for (int c = 0; c < 300; c++) cycle();
    check_int("count_sat_n0", cnt(0), CNT_EN ? 255 : 0);
    check_int("count_sat_n7", cnt(N-1), CNT_EN ? 255 : 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
